uart_tx_frame: RTL and testbench
================================

Name: uart_tx_frame

Overview:
Parametrised UART transmitter, successor to the fixed 8N1 logger transmitter. Adds configurable data width, parity, stop-bit count and oversampling. Adds a one-entry holding register with a valid/ready handshake so frames go out back-to-back with no idle gap. Sits between the logger's record formatter and the serial pin.

Parameters:
CLK_HZ, 22118400, system clock frequency in Hz
BAUD, 9600, line rate in bit/s
OVERSAMPLE, 16, baud ticks per bit (4..16)
DATA_BITS, 8, data bits per frame (5..9), sent LSB first
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
din_valid  in  1  producer offers din_data this cycle
din_data  in  DATA_BITS  word to send
din_ready  out  1  holding register empty; transfer occurs when din_valid & din_ready at a rising edge
tx  out  1  serial line, idle high, registered
tx_busy  out  1  frame in progress or holding register full
tx_done  out  1  one-cycle pulse after the last stop bit of each frame

Behaviour:
- Reset (async, active-high): tx = 1, din_ready = 1, tx_busy = 0, tx_done = 0, state IDLE, holding register empty, all counters 0.
- Divider: DIV = CLK_HZ/(BAUD*OVERSAMPLE) - 1, integer division, elaborated as a constant; width = clog2(DIV+1), minimum 1. The baud counter is held at 0 in IDLE and free-runs otherwise. A tick fires when the counter equals DIV, then the counter wraps to 0.
- Bit period: BIT_CLKS = (DIV+1)*OVERSAMPLE clocks, identical for every bit, including start, parity and stop.
- Frame: start(0), DATA_BITS data bits LSB first, an optional parity bit, then STOP_BITS stop bits of 1.
  - Odd parity: the parity bit makes the total count of ones (data plus parity) odd.
  - Even parity: the parity bit makes that count even.
- Holding register:
  - Loaded on an accepted transfer.
  - din_ready = !full. A din_valid while full is ignored and the data is not captured.
  - Emptied in the same cycle its contents are moved to the shift register.
- State machine: IDLE, START, DATA, PAR, STOP.
  - IDLE: if full, load the shifter, go to START, tx <= 0. With an accept at edge k, tx is low after edge k+1 and din_ready is high again after edge k+1.
  - START: after BIT_CLKS clocks -> DATA, tx <= data[0].
  - DATA: shift one bit per BIT_CLKS clocks. After DATA_BITS bits -> PAR if PARITY != 0, else STOP.
  - PAR: tx <= parity for BIT_CLKS clocks, then -> STOP.
  - STOP: tx <= 1 for STOP_BITS*BIT_CLKS clocks. At the end, pulse tx_done for one cycle.
    - If the holding register is full: load it, go directly to START (tx falls in the same cycle tx_done is high; zero idle clocks). The baud counter does not restart.
    - Otherwise go to IDLE.
- tx_busy = (state != IDLE) | full.
- Simultaneous events: an accept in the same cycle the holding register is emptied is impossible, because din_ready was low. An accept in the last STOP cycle, while the holding register is empty, is held and the frame starts after IDLE, one cycle later.
- Reset mid-frame: tx returns high immediately (asynchronous); the pending word is discarded and no tx_done is issued.
- Parameter values outside their ranges are an elaboration error.

Test Plan:
1. 8N1, CLK_HZ=614400, BAUD=9600 (DIV=3, BIT_CLKS=64); send 0xA5 -> tx 0,1,0,1,0,0,1,0,1,1, each for exactly 64 clocks; tx_done pulses once, 641 clocks after the accepting edge; tx_busy falls with it.
2. PARITY=2, send 0x07 -> parity bit 1; PARITY=1, send 0x07 -> parity bit 0; frame length 11*64 clocks.
3. DATA_BITS=7, STOP_BITS=2, send 0x55 -> start, 1010101, two stop bits of 64 clocks each (128 clocks high); tx_done after the second stop bit.
4. Back-to-back: 0x31 accepted, then 0x32 offered continuously -> 0x32 accepted 2 clocks after 0x31; the stop bit of 0x31 is followed immediately by the start bit of 0x32 (zero idle clocks); din_ready stays low until 0x32 moves to the shifter.
5. Full holding register: offer 0x33 while 0x32 is pending -> not accepted, din_ready = 0; it is accepted only after 0x32 loads; 0x32 and then 0x33 appear on the line, with no loss or duplication.
6. Assert reset during the 4th data bit -> tx = 1, din_ready = 1, tx_busy = 0 with no clock edge; no tx_done; the next accepted byte produces a complete, correct frame.

Source files
------------

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter with a one-entry holding register in front of the shifter.
// Latency: an accept at edge k drives the start bit after edge k+1; the frame lasts (1+DATA_BITS+par+STOP_BITS)*BIT_CLKS clocks.
// Backpressure: din_ready = !full; a word waiting in the holding register follows the current frame with zero idle clocks.
// Ports: clk/reset (async, active-high); din_valid/din_data/din_ready input handshake;
//        tx serial line (idle high); tx_busy frame active or word pending; tx_done one-cycle end-of-frame pulse.
`timescale 1ns/1ps
module uart_tx_frame #(
  parameter int CLK_HZ     = 22118400,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 din_valid,
  input  logic [DATA_BITS-1:0] din_data,
  output logic                 din_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int DIV   = CLK_HZ / (BAUD * OVERSAMPLE) - 1;
  localparam int DIV_W = (DIV > 0) ? $clog2(DIV + 1) : 1;
  localparam int OS_W  = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(DIV);
  localparam logic [OS_W-1:0]  OS_MAX   = OS_W'(OVERSAMPLE - 1);
  localparam logic [3:0]       DATA_MAX = 4'(DATA_BITS - 1);
  localparam logic [3:0]       STOP_MAX = 4'(STOP_BITS - 1);

  if (OVERSAMPLE < 4 || OVERSAMPLE > 16) begin : g_bad_os
    $error("uart_tx_frame: OVERSAMPLE must be 4..16");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_tx_frame: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_par
    $error("uart_tx_frame: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_frame: STOP_BITS must be 1 or 2");
  end
  if (DIV < 0) begin : g_bad_div
    $error("uart_tx_frame: CLK_HZ too low for BAUD*OVERSAMPLE");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t               state;
  logic [DIV_W-1:0]     baud_cnt;
  logic [OS_W-1:0]      os_cnt;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] hold;
  logic                 par_bit;
  logic                 full;

  logic accept;
  logic tick;
  logic bit_end;
  logic frame_end;
  logic load;

  assign accept    = din_valid & ~full;
  assign tick      = (state != IDLE) && (baud_cnt == DIV_MAX);
  // A bit period ends on the last baud tick of the oversample group.
  assign bit_end   = tick && (os_cnt == OS_MAX);
  assign frame_end = (state == STOP) && bit_end && (bit_cnt == STOP_MAX);
  // The holding register drains either from IDLE or straight out of the
  // last stop bit, which is what gives back-to-back frames no idle gap.
  assign load      = full && ((state == IDLE) || frame_end);

  assign din_ready = ~full;
  assign tx_busy   = (state != IDLE) | full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      os_cnt   <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      hold     <= '0;
      par_bit  <= 1'b0;
      full     <= 1'b0;
      tx       <= 1'b1;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;

      if (accept) begin
        hold <= din_data;
        full <= 1'b1;
      end

      // Counters sit at zero in IDLE so the first bit is always full length;
      // they are never restarted across a back-to-back frame boundary.
      if (state == IDLE) begin
        baud_cnt <= '0;
        os_cnt   <= '0;
      end else if (tick) begin
        baud_cnt <= '0;
        os_cnt   <= (os_cnt == OS_MAX) ? '0 : os_cnt + OS_W'(1);
      end else begin
        baud_cnt <= baud_cnt + DIV_W'(1);
      end

      case (state)
        IDLE: begin
          tx <= 1'b1;
        end
        START: begin
          if (bit_end) begin
            tx      <= shreg[0];
            shreg   <= shreg >> 1;
            bit_cnt <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_cnt == DATA_MAX) begin
              bit_cnt <= '0;
              if (PARITY != 0) begin
                tx    <= par_bit;
                state <= PAR;
              end else begin
                tx    <= 1'b1;
                state <= STOP;
              end
            end else begin
              tx      <= shreg[0];
              shreg   <= shreg >> 1;
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end
        PAR: begin
          if (bit_end) begin
            tx      <= 1'b1;
            bit_cnt <= '0;
            state   <= STOP;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (bit_cnt == STOP_MAX) begin
              tx_done <= 1'b1;
              bit_cnt <= '0;
              state   <= IDLE;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase

      // Placed last so it overrides the STOP->IDLE move when a word waits.
      if (load) begin
        shreg   <= hold;
        par_bit <= (PARITY == 1) ? ~^hold : ^hold;
        full    <= 1'b0;
        tx      <= 1'b0;
        state   <= START;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
`timescale 1ns/1ps
module tb_uart_tx_frame;

  localparam int BIT = 64;

  logic       clk;
  logic       reset;
  logic [3:0] vld;
  logic [7:0] dat [4];
  logic [3:0] rdys, txs, busys, dones;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  // Expected words per DUT: {parity bit, data}
  logic [8:0] exp_q [4][$];

  // DUT 0: 8N1, 1: 8E1, 2: 8O1, 3: 7N2
  int dbits [4] = '{8, 8, 8, 7};
  int pen   [4] = '{0, 1, 1, 0};
  int nstop [4] = '{1, 1, 1, 2};

  uart_tx_frame #(.CLK_HZ(614400), .BAUD(9600), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
    .clk(clk), .reset(reset), .din_valid(vld[0]), .din_data(dat[0]), .din_ready(rdys[0]),
    .tx(txs[0]), .tx_busy(busys[0]), .tx_done(dones[0]));
  uart_tx_frame #(.CLK_HZ(614400), .BAUD(9600), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_b (
    .clk(clk), .reset(reset), .din_valid(vld[1]), .din_data(dat[1]), .din_ready(rdys[1]),
    .tx(txs[1]), .tx_busy(busys[1]), .tx_done(dones[1]));
  uart_tx_frame #(.CLK_HZ(614400), .BAUD(9600), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_c (
    .clk(clk), .reset(reset), .din_valid(vld[2]), .din_data(dat[2]), .din_ready(rdys[2]),
    .tx(txs[2]), .tx_busy(busys[2]), .tx_done(dones[2]));
  uart_tx_frame #(.CLK_HZ(614400), .BAUD(9600), .OVERSAMPLE(16), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_d (
    .clk(clk), .reset(reset), .din_valid(vld[3]), .din_data(dat[3][6:0]), .din_ready(rdys[3]),
    .tx(txs[3]), .tx_busy(busys[3]), .tx_done(dones[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Serial-line monitor: decodes frames, checks bit lengths, framing,
  // tx_done placement, and pops/compares against the expected queue.
  task automatic mon(input int id);
    logic [15:0] fr;
    logic [7:0]  d;
    logic [8:0]  e;
    logic        stable, aborted, stops_ok;
    int          nb;
    nb = 1 + dbits[id] + pen[id] + nstop[id];
    @(negedge clk);
    forever begin
      if (reset !== 1'b0 || txs[id] !== 1'b0) begin
        @(negedge clk);
      end else begin
        fr = '0; stable = 1'b1; aborted = 1'b0;
        for (int b = 0; b < nb && !aborted; b++) begin
          for (int c = 0; c < BIT; c++) begin
            if (reset !== 1'b0) begin aborted = 1'b1; break; end
            if (c == 0) fr[b] = txs[id];
            else if (txs[id] !== fr[b]) stable = 1'b0;
            if (!(b == 0 && c == 0) && dones[id] !== 1'b0) stable = 1'b0;
            @(negedge clk);
          end
        end
        if (!aborted) begin
          chk($sformatf("mon%0d_done_at_frame_end", id), dones[id], 1'b1);
          chk($sformatf("mon%0d_bit_stable", id), stable, 1'b1);
          stops_ok = 1'b1;
          for (int s = 0; s < nstop[id]; s++)
            if (fr[1 + dbits[id] + pen[id] + s] !== 1'b1) stops_ok = 1'b0;
          chk($sformatf("mon%0d_framing", id), {fr[0], stops_ok}, 2'b01);
          d = '0;
          for (int i = 0; i < dbits[id]; i++) d[i] = fr[1 + i];
          chk($sformatf("mon%0d_expected_frame_pending", id), (exp_q[id].size() > 0), 1'b1);
          if (exp_q[id].size() > 0) begin
            e = exp_q[id].pop_front();
            chk($sformatf("mon%0d_data", id), d, e[7:0]);
            if (pen[id] != 0)
              chk($sformatf("mon%0d_parity", id), fr[1 + dbits[id]], e[8]);
          end
        end
      end
    end
  endtask

  initial mon(0);
  initial mon(1);
  initial mon(2);
  initial mon(3);

  // Called at a negedge; returns the edge number that accepted the word and
  // leaves the bench at the negedge right after that edge.
  task automatic send(input int id, input logic [7:0] data, output int acc);
    int w;
    vld[id] = 1'b1;
    dat[id] = data;
    w = 0;
    while (rdys[id] !== 1'b1 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    chk("send_ready", rdys[id], 1'b1);
    acc = cyc + 1;
    @(negedge clk);
    vld[id] = 1'b0;
  endtask

  task automatic wait_done(input int id, output int at);
    int w;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (dones[id] !== 1'b1 && w < 3000);
    chk("tx_done_seen", dones[id], 1'b1);
    at = cyc;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k, k1, k2, k3, t, t2, ndone;
    reset = 1'b1;
    vld   = '0;
    for (int i = 0; i < 4; i++) dat[i] = '0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("reset_tx_%0d", i), txs[i], 1'b1);
      chk($sformatf("reset_ready_%0d", i), rdys[i], 1'b1);
      chk($sformatf("reset_busy_%0d", i), busys[i], 1'b0);
      chk($sformatf("reset_done_%0d", i), dones[i], 1'b0);
    end
    #2 reset = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // 1: 8N1 0xA5 -> line 0,1,0,1,0,0,1,0,1,1
    exp_q[0].push_back({1'b0, 8'hA5});
    send(0, 8'hA5, k);
    chk("t1_ready_low_while_full", rdys[0], 1'b0);
    chk("t1_busy_while_full", busys[0], 1'b1);
    chk("t1_tx_idle_before_start", txs[0], 1'b1);
    @(negedge clk);
    chk("t1_start_bit", txs[0], 1'b0);
    chk("t1_ready_after_load", rdys[0], 1'b1);
    wait_done(0, t);
    chk("t1_done_latency", t - k, 641);
    chk("t1_busy_falls_with_done", busys[0], 1'b0);
    @(negedge clk);
    chk("t1_done_one_cycle", dones[0], 1'b0);

    // 2: 0x07 even parity -> 1, odd parity -> 0; 11 bits
    exp_q[1].push_back({1'b1, 8'h07});
    send(1, 8'h07, k);
    wait_done(1, t);
    chk("t2_even_frame_len", t - k, 1 + 11 * BIT);
    exp_q[2].push_back({1'b0, 8'h07});
    send(2, 8'h07, k);
    wait_done(2, t);
    chk("t2_odd_frame_len", t - k, 1 + 11 * BIT);

    // 3: 7N2 0x55 -> start, 1010101, two stop bits
    exp_q[3].push_back({1'b0, 8'h55});
    send(3, 8'h55, k);
    wait_done(3, t);
    chk("t3_7n2_frame_len", t - k, 1 + 10 * BIT);

    // 4/5: back-to-back and full holding register
    exp_q[0].push_back({1'b0, 8'h31});
    exp_q[0].push_back({1'b0, 8'h32});
    exp_q[0].push_back({1'b0, 8'h33});
    send(0, 8'h31, k1);
    send(0, 8'h32, k2);
    chk("t4_second_accept_gap", k2 - k1, 2);
    fork
      send(0, 8'h33, k3);
      begin
        wait_done(0, t);
        chk("t4_first_done", t - k1, 641);
        chk("t4_zero_gap_start", txs[0], 1'b0);
      end
    join
    chk("t5_third_accept_after_load", k3 - k1, 642);
    wait_done(0, t2);
    chk("t5_second_done", t2 - k1, 641 + 640);
    wait_done(0, t2);
    chk("t5_third_done", t2 - k1, 641 + 1280);

    // 6: reset during 4th data bit of 0xC3 (d3 = 0) with 0x3C pending
    send(0, 8'hC3, k);
    send(0, 8'h3C, k2);
    while (cyc < k + 1 + 4 * BIT + 30) @(negedge clk);
    chk("t6_fourth_data_bit", txs[0], 1'b0);
    chk("t6_pending_full", rdys[0], 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("t6_async_tx", txs[0], 1'b1);
    chk("t6_async_ready", rdys[0], 1'b1);
    chk("t6_async_busy", busys[0], 1'b0);
    chk("t6_async_done", dones[0], 1'b0);
    @(negedge clk);
    #2 reset = 1'b0;
    ndone = 0;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if (dones[0] === 1'b1) ndone++;
    end
    chk("t6_no_done_after_reset", ndone, 0);
    chk("t6_line_idle", txs[0], 1'b1);
    exp_q[0].push_back({1'b0, 8'h5A});
    send(0, 8'h5A, k);
    wait_done(0, t);
    chk("t6_recovery_frame", t - k, 641);

    repeat (100) @(negedge clk);
    for (int i = 0; i < 4; i++)
      chk($sformatf("queue_drained_%0d", i), exp_q[i].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
